// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//  Revision    : 1.0
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    localparam int DEFAULT_MEM_BYTES = 32;
    localparam int PERF_CNT_W        = 32;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_perf.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_perf
//  Description : Two saturating event counters (CPU stall cycles, loader
//                grants). Instantiated only when DMEM_ARB_PERF_EN is defined.
//  Revision    : 1.0
// ============================================================================
module dmem_arb_perf
    import dmem_arb_pkg::*;
#(
    parameter int CNT_W = PERF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             gnt_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] gnt_cnt_o
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] gnt_cnt_q,   gnt_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        gnt_cnt_d   = gnt_cnt_q;
        if (stall_i && (stall_cnt_q != c_cnt_max)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (gnt_i && (gnt_cnt_q != c_cnt_max)) begin
            gnt_cnt_d = gnt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            gnt_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            gnt_cnt_q   <= gnt_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign gnt_cnt_o   = gnt_cnt_q;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the data-memory port between the CPU MEM stage and a
//                debug/loader requester, with an aging counter that bounds
//                loader starvation. Optional macro DMEM_ARB_PERF_EN adds
//                saturating stall/grant performance counters.
//  Revision    : 1.0
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
    parameter int MAX_WAIT  = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_rvalid_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_stall_cnt_o,
    output logic [PERF_CNT_W-1:0] perf_dbg_cnt_o
`endif
);

    localparam int                c_wait_w    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MAX_WAIT);
    localparam logic [ADDR_W-1:0] c_mem_limit = ADDR_W'(MEM_BYTES);

    owner_e              w_owner;
    logic                w_cpu_act;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_in_range;

    logic [c_wait_w-1:0] wait_cnt_q,   wait_cnt_d;
    logic [DATA_W-1:0]   dbg_rdata_q,  dbg_rdata_d;
    logic                dbg_rvalid_q, dbg_rvalid_d;

    assign w_cpu_act = cpu_req_i & start_i;

    // CPU is primary; the loader only wins a contended cycle once it has aged out.
    always_comb begin
        w_owner = OWN_NONE;
        if (dbg_req_i && !w_cpu_act) begin
            w_owner = OWN_DBG;
        end else if (w_cpu_act && !dbg_req_i) begin
            w_owner = OWN_CPU;
        end else if (w_cpu_act && dbg_req_i) begin
            w_owner = (wait_cnt_q == c_wait_max) ? OWN_DBG : OWN_CPU;
        end
    end

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        case (w_owner)
            OWN_CPU: begin
                w_sel_we    = cpu_we_i;
                w_sel_addr  = cpu_addr_i;
                w_sel_wdata = cpu_wdata_i;
            end
            OWN_DBG: begin
                w_sel_we    = dbg_we_i;
                w_sel_addr  = dbg_addr_i;
                w_sel_wdata = dbg_wdata_i;
            end
            default: begin
                w_sel_we    = 1'b0;
                w_sel_addr  = '0;
                w_sel_wdata = '0;
            end
        endcase
    end

    assign w_in_range  = (w_sel_addr < c_mem_limit);

    // Strobes are gated by reset so no write or handshake escapes while it is held.
    assign mem_we_o    = w_sel_we & w_in_range & rst_i;
    assign mem_addr_o  = w_sel_addr;
    assign mem_wdata_o = w_sel_wdata;
    assign dbg_gnt_o   = (w_owner == OWN_DBG) & rst_i;
    assign cpu_stall_o = w_cpu_act & (w_owner == OWN_DBG) & rst_i;
    assign cpu_rdata_o = ((w_owner == OWN_CPU) && !cpu_we_i && w_in_range) ? mem_rdata_i : '0;

    always_comb begin
        wait_cnt_d   = wait_cnt_q;
        dbg_rdata_d  = dbg_rdata_q;
        dbg_rvalid_d = 1'b0;
        if (!dbg_req_i || (w_owner == OWN_DBG)) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != c_wait_max) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if ((w_owner == OWN_DBG) && !dbg_we_i) begin
            dbg_rvalid_d = 1'b1;
            dbg_rdata_d  = w_in_range ? mem_rdata_i : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt_q   <= '0;
            dbg_rdata_q  <= '0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_rvalid_q <= dbg_rvalid_d;
        end
    end

    assign dbg_rdata_o  = dbg_rdata_q;
    assign dbg_rvalid_o = dbg_rvalid_q;

`ifdef DMEM_ARB_PERF_EN
    dmem_arb_perf #(
        .CNT_W (PERF_CNT_W)
    ) u_perf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (cpu_stall_o),
        .gnt_i       (dbg_gnt_o),
        .stall_cnt_o (perf_stall_cnt_o),
        .gnt_cnt_o   (perf_dbg_cnt_o)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Scoreboard bench for dmem_arbiter with a byte-array memory.
//  Revision    : 1.0
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic        cpu_req_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
    logic        cpu_stall_o;
    logic        dbg_req_i, dbg_we_i;
    logic [31:0] dbg_addr_i, dbg_wdata_i, dbg_rdata_o;
    logic        dbg_gnt_o, dbg_rvalid_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall_cnt_o, perf_dbg_cnt_o;
`endif

    dmem_arbiter u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_rdata_o  (cpu_rdata_o),
        .cpu_stall_o  (cpu_stall_o),
        .dbg_req_i    (dbg_req_i),
        .dbg_we_i     (dbg_we_i),
        .dbg_addr_i   (dbg_addr_i),
        .dbg_wdata_i  (dbg_wdata_i),
        .dbg_gnt_o    (dbg_gnt_o),
        .dbg_rdata_o  (dbg_rdata_o),
        .dbg_rvalid_o (dbg_rvalid_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_dbg_cnt_o   (perf_dbg_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 32 bytes, little-endian; out-of-range reads return a marker
    // so a missing range check in the arbiter shows up as wrong data.
    logic [7:0] mem [0:31];

    always_comb begin
        mem_rdata_i = 32'hBAD0_BAD0;
        if (mem_addr_o < 32'd29) begin
            mem_rdata_i = {mem[mem_addr_o[4:0] + 5'd3], mem[mem_addr_o[4:0] + 5'd2],
                           mem[mem_addr_o[4:0] + 5'd1], mem[mem_addr_o[4:0]]};
        end
    end

    always @(posedge clk) begin
        if (mem_we_o && (mem_addr_o < 32'd29)) begin
            mem[mem_addr_o[4:0]]        <= mem_wdata_o[7:0];
            mem[mem_addr_o[4:0] + 5'd1] <= mem_wdata_o[15:8];
            mem[mem_addr_o[4:0] + 5'd2] <= mem_wdata_o[23:16];
            mem[mem_addr_o[4:0] + 5'd3] <= mem_wdata_o[31:24];
        end
    end

    typedef struct {
        int          id;
        logic        gnt;
        logic        stall;
        logic        we;
        logic        chk_cpu;
        logic [31:0] cpu_rdata;
        logic        rvalid;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL v%0d %s: got %h expected %h", id, nm, act, exp);
        end
    endtask

    // Monitor: pops one expected record per observed cycle, away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt",    e.id, {31'd0, dbg_gnt_o},    {31'd0, e.gnt});
                chk("stall",  e.id, {31'd0, cpu_stall_o},  {31'd0, e.stall});
                chk("mem_we", e.id, {31'd0, mem_we_o},     {31'd0, e.we});
                chk("rvalid", e.id, {31'd0, dbg_rvalid_o}, {31'd0, e.rvalid});
                chk("rdata",  e.id, dbg_rdata_o, e.rdata);
                if (e.chk_cpu) chk("cpu_rdata", e.id, cpu_rdata_o, e.cpu_rdata);
            end
        end
    end

    task automatic step(
        input logic rst, input logic start,
        input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
        input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
        input logic e_gnt, input logic e_stall, input logic e_we,
        input logic e_chk_cpu, input logic [31:0] e_cpu,
        input logic e_rv, input logic [31:0] e_rd);
        exp_t e;
        @(posedge clk);
        #1;
        rst_i = rst;       start_i = start;
        cpu_req_i = creq;  cpu_we_i = cwe;  cpu_addr_i = caddr;  cpu_wdata_i = cwd;
        dbg_req_i = dreq;  dbg_we_i = dwe;  dbg_addr_i = daddr;  dbg_wdata_i = dwd;
        vec_id++;
        e.id = vec_id;  e.gnt = e_gnt;  e.stall = e_stall;  e.we = e_we;
        e.chk_cpu = e_chk_cpu;  e.cpu_rdata = e_cpu;  e.rvalid = e_rv;  e.rdata = e_rd;
        exp_q.push_back(e);
    endtask

    localparam logic [31:0] BEEF = 32'hDEAD_BEEF;

    initial begin
        rst_i = 1'b0;  start_i = 1'b0;
        cpu_req_i = 1'b0;  cpu_we_i = 1'b0;  cpu_addr_i = '0;  cpu_wdata_i = '0;
        dbg_req_i = 1'b0;  dbg_we_i = 1'b0;  dbg_addr_i = '0;  dbg_wdata_i = '0;

        //   rst st creq cwe caddr  cwd      dreq dwe daddr  dwd     gnt stl we chk cpu   rv rd
        step(0, 0, 0, 0, 32'h00, 32'h0,    0, 0, 32'h00, 32'h0,   0, 0, 0, 1, 32'h0, 0, 32'h0);
        // Loader preload with CPU halted
        step(1, 0, 0, 0, 32'h00, 32'h0,    1, 1, 32'h00, 32'd5,   1, 0, 1, 1, 32'h0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h00, 32'h0,    1, 1, 32'h04, BEEF,    1, 0, 1, 1, 32'h0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h00, 32'h0,    1, 1, 32'h08, 32'h1234,1, 0, 1, 1, 32'h0, 0, 32'h0);
        // CPU request ignored while start is low; loader reads 0x00
        step(1, 0, 1, 0, 32'h04, 32'h0,    1, 0, 32'h00, 32'h0,   1, 0, 0, 1, 32'h0, 0, 32'h0);
        step(1, 1, 1, 0, 32'h04, 32'h0,    0, 0, 32'h00, 32'h0,   0, 0, 0, 1, BEEF,  1, 32'd5);
        step(1, 1, 0, 0, 32'h00, 32'h0,    0, 0, 32'h00, 32'h0,   0, 0, 0, 1, 32'h0, 0, 32'd5);
        step(1, 1, 0, 0, 32'h00, 32'h0,    1, 0, 32'h08, 32'h0,   1, 0, 0, 1, 32'h0, 0, 32'd5);
        step(1, 1, 0, 0, 32'h00, 32'h0,    0, 0, 32'h00, 32'h0,   0, 0, 0, 1, 32'h0, 1, 32'h1234);
        step(1, 1, 0, 0, 32'h00, 32'h0,    0, 0, 32'h00, 32'h0,   0, 0, 0, 1, 32'h0, 0, 32'h1234);
        // Out-of-range CPU store and load
        step(1, 1, 1, 1, 32'h20, 32'hAA,   0, 0, 32'h00, 32'h0,   0, 0, 0, 1, 32'h0, 0, 32'h1234);
        step(1, 1, 1, 0, 32'h20, 32'h0,    0, 0, 32'h00, 32'h0,   0, 0, 0, 1, 32'h0, 0, 32'h1234);
        // In-range CPU store, loader reads it back, then an out-of-range loader read
        step(1, 1, 1, 1, 32'h0C, 32'h55AA, 0, 0, 32'h00, 32'h0,   0, 0, 1, 1, 32'h0, 0, 32'h1234);
        step(1, 1, 0, 0, 32'h00, 32'h0,    1, 0, 32'h0C, 32'h0,   1, 0, 0, 1, 32'h0, 0, 32'h1234);
        step(1, 1, 0, 0, 32'h00, 32'h0,    1, 0, 32'h20, 32'h0,   1, 0, 0, 1, 32'h0, 1, 32'h55AA);
        step(1, 1, 0, 0, 32'h00, 32'h0,    0, 0, 32'h00, 32'h0,   0, 0, 0, 1, 32'h0, 1, 32'h0);
        // Sustained contention: CPU x3, loader x1, repeating
        step(1, 1, 1, 0, 32'h04, 32'h0,    1, 0, 32'h08, 32'h0,   0, 0, 0, 1, BEEF,  0, 32'h0);
        step(1, 1, 1, 0, 32'h04, 32'h0,    1, 0, 32'h08, 32'h0,   0, 0, 0, 1, BEEF,  0, 32'h0);
        step(1, 1, 1, 0, 32'h04, 32'h0,    1, 0, 32'h08, 32'h0,   0, 0, 0, 1, BEEF,  0, 32'h0);
        step(1, 1, 1, 0, 32'h04, 32'h0,    1, 0, 32'h08, 32'h0,   1, 1, 0, 1, 32'h0, 0, 32'h0);
        step(1, 1, 1, 0, 32'h04, 32'h0,    1, 0, 32'h08, 32'h0,   0, 0, 0, 1, BEEF,  1, 32'h1234);
        step(1, 1, 1, 0, 32'h04, 32'h0,    1, 0, 32'h08, 32'h0,   0, 0, 0, 1, BEEF,  0, 32'h1234);
        step(1, 1, 1, 0, 32'h04, 32'h0,    1, 0, 32'h08, 32'h0,   0, 0, 0, 1, BEEF,  0, 32'h1234);
        step(1, 1, 1, 0, 32'h04, 32'h0,    1, 0, 32'h08, 32'h0,   1, 1, 0, 1, 32'h0, 0, 32'h1234);
        step(1, 1, 1, 0, 32'h04, 32'h0,    1, 0, 32'h08, 32'h0,   0, 0, 0, 1, BEEF,  1, 32'h1234);
        step(1, 1, 1, 0, 32'h04, 32'h0,    1, 0, 32'h08, 32'h0,   0, 0, 0, 1, BEEF,  0, 32'h1234);
        // Reset with the aging counter at 2 and a CPU store pending
        step(0, 1, 1, 1, 32'h10, 32'h77,   1, 0, 32'h08, 32'h0,   0, 0, 0, 0, 32'h0, 0, 32'h0);
`ifdef DMEM_ARB_PERF_EN
        #2;
        chk("perf_stall", vec_id, perf_stall_cnt_o, 32'd0);
        chk("perf_dbg",   vec_id, perf_dbg_cnt_o,   32'd0);
`endif
        // After reset the loader must again wait three contended cycles
        step(1, 1, 1, 0, 32'h04, 32'h0,    1, 0, 32'h08, 32'h0,   0, 0, 0, 1, BEEF,  0, 32'h0);
        step(1, 1, 1, 0, 32'h04, 32'h0,    1, 0, 32'h08, 32'h0,   0, 0, 0, 1, BEEF,  0, 32'h0);
        step(1, 1, 1, 0, 32'h04, 32'h0,    1, 0, 32'h08, 32'h0,   0, 0, 0, 1, BEEF,  0, 32'h0);
        step(1, 1, 1, 0, 32'h04, 32'h0,    1, 0, 32'h08, 32'h0,   1, 1, 0, 1, 32'h0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h00, 32'h0,    0, 0, 32'h00, 32'h0,   0, 0, 0, 1, 32'h0, 1, 32'h1234);
        // Reset right after a granted read drops the pending rvalid
        step(1, 1, 0, 0, 32'h00, 32'h0,    1, 0, 32'h00, 32'h0,   1, 0, 0, 1, 32'h0, 0, 32'h1234);
        step(0, 1, 0, 0, 32'h00, 32'h0,    0, 0, 32'h00, 32'h0,   0, 0, 0, 1, 32'h0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h00, 32'h0,    0, 0, 32'h00, 32'h0,   0, 0, 0, 1, 32'h0, 0, 32'h0);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
